// File: rtl/mod_reg16_drain_sched_pkg.sv
// ---------------------------------------------------------------------------
// aes_sched_pkg
// Shared types and constants for the 16-byte output register drain
// scheduler: block size, byte counter type, FSM state encoding and the
// per-source valid/grant vector type.
// ---------------------------------------------------------------------------
package aes_sched_pkg;

   localparam int N_BYTES = 16;
   localparam int CNT_W   = $clog2(N_BYTES);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} sched_state_t;

   typedef logic [1:0]       src_vec_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // Counter value during the push of the final byte of a block.
   localparam cnt_t LAST_BYTE = cnt_t'(N_BYTES - 1);

endpackage

// File: rtl/mod_reg16_drain_sched_if.sv
// ---------------------------------------------------------------------------
// mod_reg16_drain_sched_if
// Bundles the producer handshake, register control and FIFO write signals
// of the drain scheduler.
//   master : the scheduler (drives grants, register strobes, FIFO push,
//            status).
//   slave  : the surrounding logic (producers, register, FIFO).
// Signals:
//   blk_valid [2]  per-source block ready          (slave -> master)
//   blk_ready [2]  one-hot, one-cycle grant         (master -> slave)
//   sel_src        register input mux select        (master -> slave)
//   reg_wr_en      register parallel-load strobe    (master -> slave)
//   reg_req        register byte pop strobe         (master -> slave)
//   reg_empty      register has no bytes left       (slave -> master)
//   fifo_full      downstream FIFO cannot accept    (slave -> master)
//   fifo_push      register byte valid, write FIFO  (master -> slave)
//   byte_cnt  [4]  bytes pushed in current block    (master -> slave)
//   busy           scheduler not idle               (master -> slave)
//   blk_done       one-cycle end-of-block pulse     (master -> slave)
//   err            sticky register-protocol error   (master -> slave)
// ---------------------------------------------------------------------------
interface mod_reg16_drain_sched_if;
   import aes_sched_pkg::*;

   src_vec_t blk_valid;
   src_vec_t blk_ready;
   logic     sel_src;
   logic     reg_wr_en;
   logic     reg_req;
   logic     reg_empty;
   logic     fifo_full;
   logic     fifo_push;
   cnt_t     byte_cnt;
   logic     busy;
   logic     blk_done;
   logic     err;

   modport master (
      input  blk_valid, reg_empty, fifo_full,
      output blk_ready, sel_src, reg_wr_en, reg_req, fifo_push,
             byte_cnt, busy, blk_done, err
   );

   modport slave (
      output blk_valid, reg_empty, fifo_full,
      input  blk_ready, sel_src, reg_wr_en, reg_req, fifo_push,
             byte_cnt, busy, blk_done, err
   );

endinterface

// File: rtl/mod_reg16_drain_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from req and the
// internal priority pointer; the pointer is loaded from `ptr` when `update`
// is high (the scheduler does this once per block, handing priority to the
// source that was not just served).
// Ports:
//   clk, reset  clock, synchronous active-high reset (pointer -> 0)
//   req   [2]   per-source request
//   ptr         pointer value to load on update
//   update      load strobe for the pointer
//   gnt   [2]   one-hot grant (0 when no request)
//   gnt_id      index of the granted source
// ---------------------------------------------------------------------------
module rr_arb2
   import aes_sched_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  src_vec_t req,
   input  logic     ptr,
   input  logic     update,
   output src_vec_t gnt,
   output logic     gnt_id
);

   logic ptr_q;
   logic ptr_d;

   // NOTE: every signal written in an always_comb gets a default first, so
   // no path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      ptr_d = ptr_q;
      if (update) begin
         ptr_d = ptr;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // their inputs from the same edge regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Single request wins outright; on contention the pointer decides.
   always_comb begin
      gnt_id = 1'b0;
      case (req)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ptr_q;
         default: gnt_id = 1'b0;
      endcase
      gnt = (req == 2'b00) ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);
   end

endmodule

// File: rtl/mod_reg16_drain_sched.sv
// ---------------------------------------------------------------------------
// mod_reg16_drain_sched
// Sequences the 16-byte parallel-load / byte-serial register after the last
// AddRoundKey stage: grants the register to one of two block producers
// (round robin), pulses the parallel load, then drains the 16 bytes into
// the downstream byte FIFO at one byte per two cycles, stalling on FIFO full.
// Ports:
//   clk    clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    scheduler side (master) of mod_reg16_drain_sched_if
// ---------------------------------------------------------------------------
module mod_reg16_drain_sched
   import aes_sched_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   mod_reg16_drain_sched_if.master        bus
);

   sched_state_t state_q,     state_d;
   logic         phase_q,     phase_d;
   cnt_t         byte_cnt_q,  byte_cnt_d;
   logic         err_q,       err_d;
   src_vec_t     blk_ready_q, blk_ready_d;
   logic         sel_src_q,   sel_src_d;
   logic         reg_wr_en_q, reg_wr_en_d;
   logic         blk_done_q,  blk_done_d;
   logic         busy_q,      busy_d;

   src_vec_t     arb_gnt;
   logic         arb_gnt_id;
   logic         arb_update;
   logic         last_push;

   // At DONE the pointer is loaded with the complement of the source just
   // served, so the other producer wins the next tie.
   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (bus.blk_valid),
      .ptr    (~sel_src_q),
      .update (arb_update),
      .gnt    (arb_gnt),
      .gnt_id (arb_gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      byte_cnt_d  = byte_cnt_q;
      err_d       = err_q;
      sel_src_d   = sel_src_q;
      blk_ready_d = '0;
      reg_wr_en_d = 1'b0;
      blk_done_d  = 1'b0;
      arb_update  = 1'b0;
      // Push cycle of the 16th byte; the counter wraps to 0 on this push.
      last_push   = phase_q && (byte_cnt_q == LAST_BYTE);

      case (state_q)
         IDLE: begin
            if (|bus.blk_valid) begin
               state_d     = LOAD;
               blk_ready_d = arb_gnt;
               reg_wr_en_d = 1'b1;
               sel_src_d   = arb_gnt_id;
            end
         end
         LOAD: begin
            state_d    = DRAIN;
            byte_cnt_d = '0;
            phase_d    = 1'b0;
         end
         DRAIN: begin
            if (phase_q) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               phase_d    = 1'b0;
               if (last_push) begin
                  state_d    = DONE;
                  blk_done_d = 1'b1;
               end
            end else if (!bus.fifo_full) begin
               // Only writer of the FIFO: a slot seen free at request time
               // is still free on the following push cycle.
               phase_d = 1'b1;
            end
            // The register may only run dry once the 16th byte is out.
            if (bus.reg_empty && !last_push) begin
               err_d = 1'b1;
            end
         end
         DONE: begin
            state_d    = IDLE;
            sel_src_d  = 1'b0;
            arb_update = 1'b1;
            if (!bus.reg_empty) begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         byte_cnt_q  <= '0;
         err_q       <= 1'b0;
         blk_ready_q <= '0;
         sel_src_q   <= 1'b0;
         reg_wr_en_q <= 1'b0;
         blk_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         byte_cnt_q  <= byte_cnt_d;
         err_q       <= err_d;
         blk_ready_q <= blk_ready_d;
         sel_src_q   <= sel_src_d;
         reg_wr_en_q <= reg_wr_en_d;
         blk_done_q  <= blk_done_d;
         busy_q      <= busy_d;
      end
   end

   // The pop request is qualified by the live fifo_full so no request is
   // ever issued in a cycle where the FIFO reports full.
   assign bus.reg_req   = (state_q == DRAIN) && !phase_q && !bus.fifo_full;
   // phase is only ever set inside DRAIN, so it marks the push cycle.
   assign bus.fifo_push = phase_q;
   assign bus.blk_ready = blk_ready_q;
   assign bus.sel_src   = sel_src_q;
   assign bus.reg_wr_en = reg_wr_en_q;
   assign bus.byte_cnt  = byte_cnt_q;
   assign bus.busy      = busy_q;
   assign bus.blk_done  = blk_done_q;
   assign bus.err       = err_q;

endmodule
